dlx_data_memory: RTL and testbench
==================================

DLX_DATA_MEMORY -- requirements
Module: dlx_data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width.
REQ-002 Parameter DATA_ADDR_WIDTH, default 32, byte address width.
REQ-003 Parameter MEM_DEPTH_LOG2, default 10, log2 of RAM depth in words.
REQ-004 Parameter MMIO_BASE, default 32'hFFFF_0000, base byte address of the register window.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_rd_en  input  1  read request from core MEM stage.
REQ-008 data_wr_en  input  1  write request from core MEM stage.
REQ-009 data_addr  input  DATA_ADDR_WIDTH  byte address of the access.
REQ-010 data_write  input  DATA_WIDTH  write data.
REQ-011 data_read  output  DATA_WIDTH  registered read data, consumed by core WB stage.
REQ-012 mem_ready  output  1  high once RAM initialisation is complete.
REQ-013 gpio_out  output  DATA_WIDTH  contents of GPIO register.
REQ-014 access_error  output  1  one-cycle pulse flagging a rejected access.

Function
REQ-015 Decode: RAM hit when data_addr < 4*2^MEM_DEPTH_LOG2; MMIO hit when data_addr[DATA_ADDR_WIDTH-1:4] == MMIO_BASE[DATA_ADDR_WIDTH-1:4]; RAM word index = data_addr[MEM_DEPTH_LOG2+1:2].
REQ-016 MMIO map: offset 0x0 GPIO (R/W), 0x4 cycle counter (RO), 0x8 error counter (RO), 0xC reads 0, writes ignored.
REQ-017 FSM states INIT and RUN; reset enters INIT.
REQ-018 INIT: clear pointer from 0 to 2^MEM_DEPTH_LOG2-1, writes 0 to one word per cycle; after the last word, next state RUN.
REQ-019 mem_ready = 0 in INIT, 1 in RUN (registered, rises the cycle RUN is entered).
REQ-020 In INIT all core accesses are ignored: no write, data_read loads 0, no access_error.
REQ-021 RUN write: when data_wr_en=1 and access valid, target word/register updated at the sampling edge.
REQ-022 RUN read: when data_rd_en=1 and access valid, data_read updated at the sampling edge with the addressed word (latency 1 cycle).
REQ-023 data_read holds its previous value when data_rd_en=0.
REQ-024 data_rd_en and data_wr_en together, same address: write-first; data_read returns data_write.
REQ-025 Invalid access = data_addr[1:0] != 0, or neither RAM nor MMIO hit, with rd or wr enable high.
REQ-026 Invalid access: no state change, data_read loads 0 if rd, access_error = 1 for exactly the following cycle, error counter +1.
REQ-027 Cycle counter increments every cycle from reset (INIT included), wraps 2^DATA_WIDTH-1 -> 0.
REQ-028 Error counter saturates at 2^DATA_WIDTH-1.
REQ-029 Writes to RO registers are valid accesses, silently ignored, no error.

Reset
REQ-030 rst_n=0 asynchronously forces: state INIT, clear pointer 0, data_read 0, mem_ready 0, gpio_out 0, access_error 0, both counters 0.
REQ-031 Reset asserted mid-INIT or mid-RUN restarts the full clear sequence; RAM contents are not cleared asynchronously.
REQ-032 After rst_n release, mem_ready rises exactly 2^MEM_DEPTH_LOG2 cycles after the first rising edge.

Verification
REQ-033 MEM_DEPTH_LOG2=4, release reset -> mem_ready 0 for 16 cycles, 1 thereafter; read of any RAM word returns 0.
REQ-034 RUN: write 0xDEADBEEF @0x8, next cycle read @0x8 -> data_read = 0xDEADBEEF one cycle after rd_en; idle cycle -> value held.
REQ-035 Same cycle rd+wr 0x12345678 @0x4 -> data_read = 0x12345678 next cycle.
REQ-036 Write @0x6 (misaligned) and read @0x1000 (unmapped, depth 16) -> access_error pulse each, RAM unchanged, read returns 0, error counter read @MMIO_BASE+0x8 = 2.
REQ-037 Write 0xA5 @MMIO_BASE -> gpio_out = 0xA5 next cycle; write @MMIO_BASE+0x4 -> no error, counter keeps counting.
REQ-038 Assert rst_n low during RUN after writes -> outputs zero immediately, mem_ready low, full clear repeats, previously written word reads 0.

Source files
------------

// File: rtl/dlx_data_memory.sv
// DLX data memory: word RAM cleared on reset plus a small MMIO register window
// (GPIO, free-running cycle counter, saturating access-error counter).
module dlx_data_memory #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter logic [DATA_ADDR_WIDTH-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       mem_ready,
  output logic [DATA_WIDTH-1:0]      gpio_out,
  output logic                       access_error
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic {INIT, RUN} state_t;

  state_t                      state;
  logic [MEM_DEPTH_LOG2-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]       ram [DEPTH];
  logic [DATA_WIDTH-1:0]       cyc_cnt;
  logic [DATA_WIDTH-1:0]       err_cnt;

  logic                        ram_hit;
  logic                        mmio_hit;
  logic                        req;
  logic                        bad;
  logic                        ok;
  logic                        ram_we;
  logic                        gpio_we;
  logic [MEM_DEPTH_LOG2-1:0]   word;
  logic [1:0]                  reg_sel;
  logic [DATA_WIDTH-1:0]       rd_word;

  always_comb begin
    ram_hit  = (data_addr[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2+2] == '0);
    mmio_hit = (data_addr[DATA_ADDR_WIDTH-1:4] == MMIO_BASE[DATA_ADDR_WIDTH-1:4]);
    word     = data_addr[MEM_DEPTH_LOG2+1:2];
    reg_sel  = data_addr[3:2];
    req      = data_rd_en | data_wr_en;
    // Accesses are only decoded once the clear sequence has finished.
    bad      = (state == RUN) & req &
               ((data_addr[1:0] != 2'b00) | ~(ram_hit | mmio_hit));
    ok       = (state == RUN) & req & ~bad;
    ram_we   = ok & data_wr_en & ram_hit;
    gpio_we  = ok & data_wr_en & ~ram_hit & (reg_sel == 2'd0);

    // Write-first: a simultaneous write to a writable location is forwarded.
    rd_word = '0;
    if (ram_hit) begin
      rd_word = data_wr_en ? data_write : ram[word];
    end else begin
      case (reg_sel)
        2'd0:    rd_word = data_wr_en ? data_write : gpio_out;
        2'd1:    rd_word = cyc_cnt;
        2'd2:    rd_word = err_cnt;
        default: rd_word = '0;
      endcase
    end
  end

  // RAM contents survive reset; only the synchronous clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      ram[clr_ptr] <= '0;
    end else if (ram_we) begin
      ram[word] <= data_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      clr_ptr      <= '0;
      mem_ready    <= 1'b0;
      data_read    <= '0;
      gpio_out     <= '0;
      access_error <= 1'b0;
      cyc_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      cyc_cnt      <= cyc_cnt + 1'b1;
      access_error <= bad;
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (data_rd_en) begin
            data_read <= '0;
          end
          if (clr_ptr == '1) begin
            state     <= RUN;
            mem_ready <= 1'b1;
          end
        end
        default: begin
          if (data_rd_en) begin
            data_read <= ok ? rd_word : '0;
          end
          if (gpio_we) begin
            gpio_out <= data_write;
          end
          if (bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_data_memory.sv
// Directed scoreboard bench for dlx_data_memory (16-word RAM build).
module tb_dlx_data_memory;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_rd_en = 1'b0;
  logic          data_wr_en = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_write = '0;
  logic [DW-1:0] data_read;
  logic          mem_ready;
  logic [DW-1:0] gpio_out;
  logic          access_error;

  dlx_data_memory #(
    .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(N), .MMIO_BASE(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_rd_en(data_rd_en), .data_wr_en(data_wr_en),
    .data_addr(data_addr), .data_write(data_write), .data_read(data_read),
    .mem_ready(mem_ready), .gpio_out(gpio_out), .access_error(access_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] tb_cyc;

  // Independent edge count since reset release, used as the cycle-counter reference.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input bit exp_err, input string name);
    @(negedge clk);
    data_rd_en = rd;
    data_wr_en = wr;
    data_addr  = addr;
    data_write = wdata;
    q.push_back('{rd, exp_data, exp_err, name});
  endtask

  task automatic read_cyc(input string name);
    @(negedge clk);
    data_rd_en = 1'b1;
    data_wr_en = 1'b0;
    data_addr  = MB + 32'h4;
    q.push_back('{1'b1, tb_cyc, 1'b0, name});
  endtask

  task automatic idle();
    @(negedge clk);
    data_rd_en = 1'b0;
    data_wr_en = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!mem_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        data_rd_en = 1'b0;
        data_wr_en = 1'b0;
      end
    end
    chk(name, n, 16);
  endtask

  // Monitor: every edge that samples an access yields one registered response.
  initial begin
    exp_t e;
    bit   was_rd;
    forever begin
      @(posedge clk);
      if (rst_n && (data_rd_en || data_wr_en)) begin
        was_rd = data_rd_en;
        #1;
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_access: got response, expected none queued");
        end else begin
          e = q.pop_front();
          if (was_rd) chk({e.name, "_data"}, data_read, e.data);
          chk({e.name, "_err"}, {31'b0, access_error}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_data_read", data_read, 0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 0);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_err", {31'b0, access_error}, 0);

    // Release; a misaligned read during INIT must be ignored without error
    @(negedge clk);
    rst_n      = 1'b1;
    data_rd_en = 1'b1;
    data_addr  = 32'h6;
    q.push_back('{1'b1, 32'h0, 1'b0, "init_ignored"});
    wait_ready("init_cycles");

    access(1, 0, 32'h0,  0, 32'h0, 0, "ram0_cleared");
    access(1, 0, 32'h3C, 0, 32'h0, 0, "ram15_cleared");

    access(0, 1, 32'h8, 32'hDEADBEEF, 0, 0, "wr_8");
    access(1, 0, 32'h8, 0, 32'hDEADBEEF, 0, "rd_8");
    idle();
    @(negedge clk);
    chk("hold_idle", data_read, 32'hDEADBEEF);

    access(1, 1, 32'h4, 32'h12345678, 32'h12345678, 0, "rdwr_4");
    access(1, 0, 32'h4, 0, 32'h12345678, 0, "rd_4");

    access(0, 1, 32'h6, 32'hCAFEF00D, 0, 1, "wr_misaligned");
    access(1, 0, 32'h1000, 0, 32'h0, 1, "rd_unmapped");
    idle();
    @(negedge clk);
    chk("err_pulse_one_cycle", {31'b0, access_error}, 0);
    access(1, 0, 32'h4, 0, 32'h12345678, 0, "ram_unchanged");
    access(1, 0, MB + 32'h8, 0, 32'd2, 0, "err_count");

    access(0, 1, MB, 32'hA5, 0, 0, "wr_gpio");
    idle();
    chk("gpio_out", gpio_out, 32'hA5);
    access(1, 0, MB, 0, 32'hA5, 0, "rd_gpio");
    access(0, 1, MB + 32'h4, 32'h0, 0, 0, "wr_ro_cyc");
    read_cyc("cyc_a");
    idle();
    idle();
    read_cyc("cyc_b");
    access(1, 0, MB + 32'hC, 0, 32'h0, 0, "rd_reserved");
    access(0, 1, MB + 32'hC, 32'h55, 0, 0, "wr_reserved");
    access(1, 0, MB + 32'h8, 0, 32'd2, 0, "err_count_after_ro");

    // Reset during RUN
    access(0, 1, 32'h20, 32'h11, 0, 0, "wr_20");
    access(1, 0, 32'h20, 0, 32'h11, 0, "rd_20");
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_read", data_read, 0);
    chk("mid_rst_mem_ready", {31'b0, mem_ready}, 0);
    chk("mid_rst_gpio", gpio_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reinit_cycles");
    access(1, 0, 32'h20, 0, 32'h0, 0, "rd_20_cleared");
    access(1, 0, MB + 32'h8, 0, 32'h0, 0, "err_count_reset");
    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
